// File: rtl/apb_fir_ctrl_regs.sv
// APB3 control/status slave for the FIR engine: counts, start pulse, busy/done tracking, run counter.
// Optional interrupt output enabled by defining FIR_CTRL_IRQ_EN.
module apb_fir_ctrl_regs #(
  parameter logic [31:0] BASE_ADDR    = 32'd32,
  parameter int          DATA_W       = 32,
  parameter int          COEF_CNT_W   = 6,
  parameter int          SAMPLE_CNT_W = 14,
  parameter int          MAX_COEF     = 32,
  parameter int          WAIT_STATES  = 0,
  parameter int          RUN_CNT_W    = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [31:0]             PADDR,
  input  logic                    PSELx,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_W-1:0]       PWDATA,
  output logic                    PREADY,
  output logic [DATA_W-1:0]       PRDATA,
  output logic                    PSLVERR,
  output logic                    Start,
  input  logic                    pracuje,
  input  logic                    DONE,
  output logic [COEF_CNT_W-1:0]   Ile_wsp,
  output logic [SAMPLE_CNT_W-1:0] Ile_probek
`ifdef FIR_CTRL_IRQ_EN
  ,
  output logic                    irq
`endif
);

  typedef enum logic [1:0] {A_IDLE, A_WAIT, A_READY} apb_st_e;
  typedef enum logic [1:0] {R_IDLE, R_RUN, R_DONE} run_st_e;

  localparam logic [2:0] IDX_CTRL    = 3'd0;
  localparam logic [2:0] IDX_STATUS  = 3'd1;
  localparam logic [2:0] IDX_RUN_CNT = 3'd2;
  localparam logic [2:0] IDX_COEF    = 3'd3;
  localparam logic [2:0] IDX_SAMPLE  = 3'd4;

  localparam logic [2:0]        WS_LAST    = 3'(WAIT_STATES - 1);
  localparam logic [DATA_W-1:0] MAX_COEF_W = DATA_W'(MAX_COEF);

  apb_st_e r_apb_st, w_apb_nxt;
  run_st_e r_run_st, w_run_nxt;
  logic [2:0]              r_wcnt, w_wcnt_nxt;
  logic                    r_start;
  logic                    r_done_sticky;
  logic [RUN_CNT_W-1:0]    r_run_cnt;
  logic [COEF_CNT_W-1:0]   r_coef;
  logic [SAMPLE_CNT_W-1:0] r_sample;
  logic                    w_irq_en;

  logic [31:0] w_off;
  logic [2:0]  w_idx;
  logic        w_in_range, w_xfer, w_busy, w_coef_bad, w_samp_zero, w_err;
  logic        w_wr_ok, w_start_ok, w_clr_cnt, w_w1c, w_done_evt;

  // The IDLE cycle that sees PSELx & !PENABLE is the setup phase; the access phase follows.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_apb_nxt  = r_apb_st;
    w_wcnt_nxt = r_wcnt;
    case (r_apb_st)
      A_IDLE: begin
        if (PSELx && !PENABLE) begin
          w_wcnt_nxt = '0;
          w_apb_nxt  = (WAIT_STATES == 0) ? A_READY : A_WAIT;
        end
      end
      A_WAIT: begin
        if (!PSELx)                 w_apb_nxt  = A_IDLE;
        else if (r_wcnt == WS_LAST) w_apb_nxt  = A_READY;
        else                        w_wcnt_nxt = r_wcnt + 3'd1;
      end
      A_READY: w_apb_nxt = A_IDLE;
      default: w_apb_nxt = A_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_apb_st <= A_IDLE;
      r_wcnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      r_apb_st <= w_apb_nxt;
      r_wcnt   <= w_wcnt_nxt;
    end
  end

  assign PREADY      = (r_apb_st == A_READY);
  assign w_xfer      = PREADY && PSELx && PENABLE;
  assign w_off       = PADDR - BASE_ADDR;
  assign w_in_range  = (PADDR >= BASE_ADDR) && (w_off < 32'd5);
  assign w_idx       = w_off[2:0];
  assign w_busy      = (r_run_st == R_RUN) || pracuje;
  assign w_coef_bad  = (r_coef == '0) || (DATA_W'(r_coef) > MAX_COEF_W);
  assign w_samp_zero = (r_sample == '0);

  always_comb begin
    w_err = 1'b0;
    if (!w_in_range) begin
      w_err = 1'b1;
    end else if (PWRITE) begin
      case (w_idx)
        IDX_CTRL:    w_err = PWDATA[0] && (w_busy || w_coef_bad || w_samp_zero);
        IDX_STATUS:  w_err = PWDATA[0];
        IDX_RUN_CNT: w_err = 1'b1;
        IDX_COEF:    w_err = w_busy || (PWDATA > MAX_COEF_W);
        IDX_SAMPLE:  w_err = w_busy;
        default:     w_err = 1'b1;
      endcase
    end
  end

  // A rejected write changes nothing, so every write side effect is gated by w_wr_ok.
  assign w_wr_ok    = w_xfer && PWRITE && !w_err;
  assign w_start_ok = w_wr_ok && (w_idx == IDX_CTRL) && PWDATA[0];
  assign w_clr_cnt  = w_wr_ok && (w_idx == IDX_CTRL) && PWDATA[1];
  assign w_w1c      = w_wr_ok && (w_idx == IDX_STATUS) && PWDATA[1];
  assign w_done_evt = (r_run_st == R_RUN) && DONE;

  always_comb begin
    w_run_nxt = r_run_st;
    case (r_run_st)
      R_IDLE:  if (w_start_ok) w_run_nxt = R_RUN;
      R_RUN:   if (DONE)       w_run_nxt = R_DONE;
      R_DONE:  w_run_nxt = w_start_ok ? R_RUN : R_IDLE;
      default: w_run_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_run_st      <= R_IDLE;
      r_start       <= 1'b0;
      r_done_sticky <= 1'b0;
      r_run_cnt     <= '0;
      r_coef        <= '0;
      r_sample      <= '0;
    end else begin
      r_run_st <= w_run_nxt;
      r_start  <= w_start_ok;
      if (w_done_evt)  r_done_sticky <= 1'b1;
      else if (w_w1c)  r_done_sticky <= 1'b0;
      if (w_clr_cnt)                            r_run_cnt <= '0;
      else if (w_done_evt && (r_run_cnt != '1)) r_run_cnt <= r_run_cnt + 1'b1;
      if (w_wr_ok && (w_idx == IDX_COEF))   r_coef   <= PWDATA[COEF_CNT_W-1:0];
      if (w_wr_ok && (w_idx == IDX_SAMPLE)) r_sample <= PWDATA[SAMPLE_CNT_W-1:0];
    end
  end

`ifdef FIR_CTRL_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_ok && (w_idx == IDX_CTRL)) r_irq_en <= PWDATA[2];
      r_irq <= r_done_sticky && r_irq_en;
    end
  end

  assign w_irq_en = r_irq_en;
  assign irq      = r_irq;
`else
  assign w_irq_en = 1'b0;
`endif

  always_comb begin
    PRDATA = '0;
    if (PREADY && !PWRITE && w_in_range) begin
      case (w_idx)
        IDX_CTRL:    PRDATA[2]                = w_irq_en;
        IDX_STATUS:  PRDATA[1:0]              = {r_done_sticky, w_busy};
        IDX_RUN_CNT: PRDATA[RUN_CNT_W-1:0]    = r_run_cnt;
        IDX_COEF:    PRDATA[COEF_CNT_W-1:0]   = r_coef;
        IDX_SAMPLE:  PRDATA[SAMPLE_CNT_W-1:0] = r_sample;
        default:     PRDATA = '0;
      endcase
    end
  end

  assign PSLVERR    = PREADY && w_err;
  assign Start      = r_start;
  assign Ile_wsp    = r_coef;
  assign Ile_probek = r_sample;

endmodule
